// File: rtl/sram_responder.sv
// sram_responder
//   Memory-side responder for the fetch engine. Read requests are accepted on
//   a valid/ready handshake. The word array is read at the accept edge. Data
//   then passes through a fixed LATENCY-stage delay pipe into a small response
//   FIFO, and responses come back in accept order. The number of requests in
//   flight is credit-limited to MAX_OUTSTANDING. This keeps the FIFO from ever
//   overflowing, so the pipe never has to stall. A handshake-free side write
//   port preloads the array.
//
// Ports
//   clk, rst_n        clock (rising edge) and synchronous active-low reset
//   m_req_vld/rdy     read request handshake
//   m_req_addr        read word address
//   m_rsp_vld/rdy     response handshake, in request order
//   m_rsp_data        read data, zero while m_rsp_vld is low
//   wr_en/addr/data   preload write port, always accepted
//   oob_err           sticky: out-of-range read or write seen since reset
//   outstanding       accepted-but-unreturned request count

module sram_responder #(
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int MEM_DEPTH       = 256,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               m_req_vld,
  output logic                               m_req_rdy,
  input  logic [ADDR_WIDTH-1:0]              m_req_addr,
  output logic                               m_rsp_vld,
  input  logic                               m_rsp_rdy,
  output logic [DATA_WIDTH-1:0]              m_rsp_data,
  input  logic                               wr_en,
  input  logic [ADDR_WIDTH-1:0]              wr_addr,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  output logic                               oob_err,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding
);

  localparam int CNT_W     = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PTR_W     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int IDX_W_RAW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int IDX_W     = (IDX_W_RAW < ADDR_WIDTH) ? IDX_W_RAW : ADDR_WIDTH;
  // When the array covers every address, no address can ever be out of range.
  localparam bit FULL_MAP  = (longint'(MEM_DEPTH) >= (longint'(1) << ADDR_WIDTH));

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  req_fire;
  logic                  rsp_fire;
  logic                  req_in_range;
  logic                  wr_in_range;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [LATENCY-1:0]    pipe_vld;
  logic [DATA_WIDTH-1:0] pipe_data [LATENCY];
  logic                  tail_vld;
  logic [DATA_WIDTH-1:0] tail_data;

  logic [DATA_WIDTH-1:0] fifo_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      fifo_cnt;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;

  generate
    if (FULL_MAP) begin : g_full_map
      assign req_in_range = 1'b1;
      assign wr_in_range  = 1'b1;
    end else begin : g_part_map
      localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);
      assign req_in_range = (m_req_addr < DEPTH_A);
      assign wr_in_range  = (wr_addr < DEPTH_A);
    end
  endgenerate

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign m_req_rdy = rst_n && (outstanding < CNT_W'(MAX_OUTSTANDING));
  assign req_fire  = m_req_vld && m_req_rdy;
  assign rsp_fire  = m_rsp_vld && m_rsp_rdy;

  assign rd_word   = req_in_range ? mem[m_req_addr[IDX_W-1:0]] : '0;

  assign tail_vld  = pipe_vld[LATENCY-1];
  assign tail_data = pipe_data[LATENCY-1];

  // The FIFO head is always older than anything in the pipe. When the FIFO is
  // empty, the pipe tail is presented directly so that the latency is exact.
  assign fifo_empty = (fifo_cnt == '0);
  assign m_rsp_vld  = fifo_empty ? tail_vld : 1'b1;
  assign m_rsp_data = !fifo_empty ? fifo_mem[rd_ptr] : (tail_vld ? tail_data : '0);

  // The tail item parks in the FIFO unless it is consumed straight off the
  // bypass in this cycle.
  assign fifo_push = tail_vld && !(fifo_empty && rsp_fire);
  assign fifo_pop  = !fifo_empty && rsp_fire;

  // Non-blocking write: a read on the same edge still sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_vld    <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        pipe_data[k] <= '0;
      end
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_cnt    <= '0;
      outstanding <= '0;
      oob_err     <= 1'b0;
    end else begin
      pipe_vld[0]  <= req_fire;
      pipe_data[0] <= req_fire ? rd_word : '0;
      for (int k = 1; k < LATENCY; k++) begin
        pipe_vld[k]  <= pipe_vld[k-1];
        pipe_data[k] <= pipe_data[k-1];
      end

      if (fifo_push) begin
        fifo_mem[wr_ptr] <= tail_data;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (fifo_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      fifo_cnt    <= fifo_cnt + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
      outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_fire);

      if ((req_fire && !req_in_range) || (wr_en && !wr_in_range)) begin
        oob_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder
//   Drives three responders side by side:
//     inst0  LATENCY=2  MEM_DEPTH=256
//     inst1  LATENCY=1  MEM_DEPTH=200
//     inst2  LATENCY=8  MEM_DEPTH=256
//   All three use MAX_OUTSTANDING=4.
//   A behavioural model keeps, for each instance, an ordered list of pending
//   responses. Each entry holds the cycle at which it becomes presentable. A
//   negedge process compares every output against the model on every cycle.
//   Literal expectations pin the key scenarios.

module tb_sram_responder;

  localparam int NI   = 3;
  localparam int MAXO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_vld  [NI];
  logic       req_rdy  [NI];
  logic [7:0] req_addr [NI];
  logic       rsp_vld  [NI];
  logic       rsp_rdy  [NI];
  logic [7:0] rsp_data [NI];
  logic       wr_en    [NI];
  logic [7:0] wr_addr  [NI];
  logic [7:0] wr_data  [NI];
  logic       oob_err  [NI];
  logic [2:0] outst    [NI];

  always #5 clk = ~clk;

  sram_responder #(.LATENCY(2), .MEM_DEPTH(256), .MAX_OUTSTANDING(MAXO)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .m_req_vld(req_vld[0]), .m_req_rdy(req_rdy[0]), .m_req_addr(req_addr[0]),
    .m_rsp_vld(rsp_vld[0]), .m_rsp_rdy(rsp_rdy[0]), .m_rsp_data(rsp_data[0]),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .oob_err(oob_err[0]), .outstanding(outst[0]));

  sram_responder #(.LATENCY(1), .MEM_DEPTH(200), .MAX_OUTSTANDING(MAXO)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .m_req_vld(req_vld[1]), .m_req_rdy(req_rdy[1]), .m_req_addr(req_addr[1]),
    .m_rsp_vld(rsp_vld[1]), .m_rsp_rdy(rsp_rdy[1]), .m_rsp_data(rsp_data[1]),
    .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .oob_err(oob_err[1]), .outstanding(outst[1]));

  sram_responder #(.LATENCY(8), .MEM_DEPTH(256), .MAX_OUTSTANDING(MAXO)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .m_req_vld(req_vld[2]), .m_req_rdy(req_rdy[2]), .m_req_addr(req_addr[2]),
    .m_rsp_vld(rsp_vld[2]), .m_rsp_rdy(rsp_rdy[2]), .m_rsp_data(rsp_data[2]),
    .wr_en(wr_en[2]), .wr_addr(wr_addr[2]), .wr_data(wr_data[2]),
    .oob_err(oob_err[2]), .outstanding(outst[2]));

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 8);
  endfunction

  function automatic int depth_of(input int i);
    return (i == 1) ? 200 : 256;
  endfunction

  int compared   = 0;
  int mismatched = 0;

  task automatic check_output(input string name, input int inst,
                              input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s inst%0d: got 0x%0h expected 0x%0h", name, inst, act, exp);
    end
  endtask

  // Behavioural model: per instance, a ring of pending responses holding
  // data and the cycle at which each may first be presented.
  int m_data  [NI][16];
  int m_ready [NI][16];
  int m_head  [NI];
  int m_size  [NI];
  bit m_oob   [NI];
  int shadow  [NI][256];
  int cyc = 0;
  bit model_valid = 0;

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      bit vld_now;
      bit rdy_now;
      int a;
      int t;
      vld_now = (m_size[i] > 0) && (m_ready[i][m_head[i]] <= cyc);
      rdy_now = (m_size[i] < MAXO);
      if (!rst_n) begin
        m_size[i] = 0;
        m_head[i] = 0;
        m_oob[i]  = 0;
      end else begin
        if (vld_now && rsp_rdy[i]) begin
          m_head[i] = (m_head[i] + 1) % 16;
          m_size[i] = m_size[i] - 1;
        end
        if (req_vld[i] && rdy_now) begin
          a = int'(req_addr[i]);
          t = (m_head[i] + m_size[i]) % 16;
          m_data[i][t]  = (a < depth_of(i)) ? shadow[i][a] : 0;
          m_ready[i][t] = cyc + lat_of(i);
          m_size[i] = m_size[i] + 1;
          if (a >= depth_of(i)) m_oob[i] = 1;
        end
        if (wr_en[i] && int'(wr_addr[i]) >= depth_of(i)) m_oob[i] = 1;
      end
      if (wr_en[i] && int'(wr_addr[i]) < depth_of(i)) shadow[i][wr_addr[i]] = int'(wr_data[i]);
    end
    if (!rst_n) model_valid = 1;
    cyc = cyc + 1;
  end

  int log_data [NI][64];
  int log_cnt  [NI];
  int max_outst [NI];

  always @(negedge clk) begin
    if (model_valid) begin
      for (int i = 0; i < NI; i++) begin
        bit ev;
        int ed;
        ev = (m_size[i] > 0) && (m_ready[i][m_head[i]] <= cyc);
        ed = ev ? m_data[i][m_head[i]] : 0;
        check_output("rsp_vld", i, 32'(rsp_vld[i]), 32'(ev));
        check_output("rsp_data", i, 32'(rsp_data[i]), ed);
        check_output("req_rdy", i, 32'(req_rdy[i]), 32'(rst_n && (m_size[i] < MAXO)));
        check_output("outstanding", i, 32'(outst[i]), m_size[i]);
        check_output("oob_err", i, 32'(oob_err[i]), 32'(m_oob[i]));
        if (rsp_vld[i] === 1'b1 && rsp_rdy[i] === 1'b1) begin
          if (log_cnt[i] < 64) log_data[i][log_cnt[i]] = int'(rsp_data[i]);
          log_cnt[i]++;
        end
        if (int'(outst[i]) > max_outst[i]) max_outst[i] = int'(outst[i]);
      end
    end
  end

  int req_list [1000];
  int idx [NI];
  int exp_list [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    for (int i = 0; i < NI; i++) begin
      req_vld[i] = 1'b0;
      req_addr[i] = 8'h00;
      wr_en[i] = 1'b0;
    end
  endtask

  task automatic reset_idx();
    for (int i = 0; i < NI; i++) idx[i] = 0;
  endtask

  task automatic clear_log();
    for (int i = 0; i < NI; i++) log_cnt[i] = 0;
  endtask

  task automatic write_all(input int addr, input int data);
    for (int i = 0; i < NI; i++) begin
      wr_en[i]   = (addr < depth_of(i));
      wr_addr[i] = 8'(addr);
      wr_data[i] = 8'(data);
    end
    tick();
    for (int i = 0; i < NI; i++) wr_en[i] = 1'b0;
  endtask

  // One cycle of traffic: each instance works through req_list independently,
  // advancing only when its request was actually accepted.
  task automatic apply_stimulus(input int n, input bit rnd, input bit rdy_hold);
    bit acc [NI];
    for (int i = 0; i < NI; i++) begin
      bit v;
      v = (idx[i] < n);
      if (rnd && $urandom_range(0, 1) == 0) v = 1'b0;
      req_vld[i]  = v;
      req_addr[i] = 8'(req_list[(idx[i] < n) ? idx[i] : 0]);
      rsp_rdy[i]  = rnd ? 1'($urandom_range(0, 1)) : rdy_hold;
      if (rnd) begin
        wr_en[i]   = ($urandom_range(0, 4) == 0);
        wr_addr[i] = 8'($urandom_range(0, 255));
        wr_data[i] = 8'($urandom_range(0, 255));
      end
      acc[i] = v && (req_rdy[i] === 1'b1);
    end
    tick();
    for (int i = 0; i < NI; i++) if (acc[i]) idx[i]++;
  endtask

  task automatic run_until_done(input int n, input bit rnd, input bit rdy_hold, input int budget);
    bit issued;
    bit drained;
    int b;
    b = budget;
    issued = 1'b0;
    while (!issued && b > 0) begin
      apply_stimulus(n, rnd, rdy_hold);
      b--;
      issued = 1'b1;
      for (int i = 0; i < NI; i++) if (idx[i] < n) issued = 1'b0;
    end
    check_output("issue_within_budget", 0, 32'(issued), 32'd1);
    set_idle();
    for (int i = 0; i < NI; i++) rsp_rdy[i] = 1'b1;
    drained = 1'b0;
    for (int k = 0; k < 64 && !drained; k++) begin
      tick();
      drained = 1'b1;
      for (int i = 0; i < NI; i++) if (outst[i] !== 3'd0) drained = 1'b0;
    end
    check_output("drain_within_budget", 0, 32'(drained), 32'd1);
  endtask

  task automatic check_log(input string name, input int inst, input int n);
    check_output({name, "_count"}, inst, log_cnt[inst], n);
    for (int k = 0; k < n; k++) begin
      if (k < log_cnt[inst]) check_output(name, inst, log_data[inst][k], exp_list[k]);
    end
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog inst0: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    set_idle();
    for (int i = 0; i < NI; i++) begin
      rsp_rdy[i] = 1'b0;
      wr_addr[i] = 8'h00;
      wr_data[i] = 8'h00;
      log_cnt[i] = 0;
      max_outst[i] = 0;
      m_head[i] = 0;
      m_size[i] = 0;
      m_oob[i] = 0;
    end
    repeat (3) tick();
    for (int i = 0; i < NI; i++) begin
      check_output("reset_req_rdy", i, 32'(req_rdy[i]), 32'd0);
      check_output("reset_rsp_vld", i, 32'(rsp_vld[i]), 32'd0);
      check_output("reset_rsp_data", i, 32'(rsp_data[i]), 32'd0);
      check_output("reset_outstanding", i, 32'(outst[i]), 32'd0);
      check_output("reset_oob", i, 32'(oob_err[i]), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) check_output("release_req_rdy", i, 32'(req_rdy[i]), 32'd1);

    // Preload the whole array, then the words the directed scenarios use.
    for (int a = 0; a < 256; a++) write_all(a, (a * 7 + 3) & 255);
    for (int a = 0; a < 4; a++) write_all(8'h10 + a, 8'hA0 + a);
    for (int a = 0; a < 6; a++) write_all(a, a + 1);
    write_all(8'h20, 8'h11);
    $display("[TB] preload done");

    // Back-to-back reads with the consumer always ready.
    reset_idx();
    clear_log();
    for (int k = 0; k < 4; k++) req_list[k] = 8'h10 + k;
    apply_stimulus(4, 1'b0, 1'b1);
    check_output("t1_no_early_vld", 0, 32'(rsp_vld[0]), 32'd0);
    apply_stimulus(4, 1'b0, 1'b1);
    check_output("t1_first_vld", 0, 32'(rsp_vld[0]), 32'd1);
    check_output("t1_first_data", 0, 32'(rsp_data[0]), 32'hA0);
    check_output("t1_outst_peak", 0, 32'(outst[0]), 32'd2);
    apply_stimulus(4, 1'b0, 1'b1);
    check_output("t1_second_data", 0, 32'(rsp_data[0]), 32'hA1);
    apply_stimulus(4, 1'b0, 1'b1);
    check_output("t1_third_data", 0, 32'(rsp_data[0]), 32'hA2);
    apply_stimulus(4, 1'b0, 1'b1);
    check_output("t1_fourth_data", 0, 32'(rsp_data[0]), 32'hA3);
    check_output("t1_outst_tail", 0, 32'(outst[0]), 32'd1);
    run_until_done(4, 1'b0, 1'b1, 20);
    for (int k = 0; k < 4; k++) exp_list[k] = 8'hA0 + k;
    for (int i = 0; i < NI; i++) check_log("t1_order", i, 4);

    // Backpressure: consumer stalled, six reads offered.
    reset_idx();
    clear_log();
    for (int k = 0; k < 6; k++) req_list[k] = k;
    repeat (12) apply_stimulus(6, 1'b0, 1'b0);
    for (int i = 0; i < NI; i++) begin
      check_output("t2_accepted", i, idx[i], 4);
      check_output("t2_req_rdy_low", i, 32'(req_rdy[i]), 32'd0);
      check_output("t2_outst_full", i, 32'(outst[i]), 32'd4);
      check_output("t2_vld_held", i, 32'(rsp_vld[i]), 32'd1);
      check_output("t2_data_held", i, 32'(rsp_data[i]), 32'd1);
    end
    run_until_done(6, 1'b0, 1'b1, 60);
    for (int k = 0; k < 6; k++) exp_list[k] = k + 1;
    for (int i = 0; i < NI; i++) check_log("t2_order", i, 6);

    // Same-edge write and read: old data first, then new data.
    reset_idx();
    clear_log();
    req_list[0] = 8'h20;
    req_list[1] = 8'h20;
    for (int i = 0; i < NI; i++) begin
      wr_en[i] = 1'b1;
      wr_addr[i] = 8'h20;
      wr_data[i] = 8'h55;
    end
    apply_stimulus(2, 1'b0, 1'b1);
    for (int i = 0; i < NI; i++) wr_en[i] = 1'b0;
    run_until_done(2, 1'b0, 1'b1, 20);
    exp_list[0] = 8'h11;
    exp_list[1] = 8'h55;
    for (int i = 0; i < NI; i++) check_log("t3_rw_same_edge", i, 2);

    // Out of range on the 200-word instance.
    reset_idx();
    clear_log();
    req_list[0] = 8'hF0;
    run_until_done(1, 1'b0, 1'b1, 20);
    write_all(8'hF0, 8'hFF);
    for (int i = 0; i < NI; i++) wr_en[i] = 1'b1;
    for (int i = 0; i < NI; i++) begin
      wr_addr[i] = 8'hF0;
      wr_data[i] = 8'hFF;
    end
    tick();
    set_idle();
    reset_idx();
    run_until_done(1, 1'b0, 1'b1, 20);
    check_output("t4_oob_set", 1, 32'(oob_err[1]), 32'd1);
    check_output("t4_oob_clear_inrange", 0, 32'(oob_err[0]), 32'd0);
    exp_list[0] = 0;
    exp_list[1] = 0;
    check_log("t4_oob_data", 1, 2);
    exp_list[0] = 8'h93;
    exp_list[1] = 8'hFF;
    check_log("t4_inrange_data", 0, 2);

    // Reset with three requests in flight.
    reset_idx();
    clear_log();
    for (int k = 0; k < 3; k++) req_list[k] = 8'h10 + k;
    repeat (3) apply_stimulus(3, 1'b0, 1'b0);
    set_idle();
    rst_n = 1'b0;
    tick();
    for (int i = 0; i < NI; i++) begin
      check_output("t5_rsp_vld", i, 32'(rsp_vld[i]), 32'd0);
      check_output("t5_rsp_data", i, 32'(rsp_data[i]), 32'd0);
      check_output("t5_outst", i, 32'(outst[i]), 32'd0);
      check_output("t5_req_rdy_in_reset", i, 32'(req_rdy[i]), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      check_output("t5_req_rdy_release", i, 32'(req_rdy[i]), 32'd1);
      rsp_rdy[i] = 1'b1;
    end
    repeat (12) tick();
    for (int i = 0; i < NI; i++) begin
      check_output("t5_no_stale_rsp", i, log_cnt[i], 0);
      check_output("t5_oob_cleared", i, 32'(oob_err[i]), 32'd0);
    end
    reset_idx();
    req_list[0] = 8'h12;
    run_until_done(1, 1'b0, 1'b1, 20);
    exp_list[0] = 8'hA2;
    for (int i = 0; i < NI; i++) check_log("t5_data_kept", i, 1);

    // Random traffic with random preload writes interleaved.
    reset_idx();
    clear_log();
    for (int i = 0; i < NI; i++) max_outst[i] = 0;
    for (int k = 0; k < 1000; k++) req_list[k] = $urandom_range(0, 255);
    run_until_done(1000, 1'b1, 1'b0, 30000);
    for (int i = 0; i < NI; i++) begin
      check_output("t6_max_outst_le4", i, 32'(max_outst[i] <= MAXO), 32'd1);
      check_output("t6_rsp_count", i, log_cnt[i], 1000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
